// File: rtl/alp_dq_seq_if.sv
// ============================================================================
// Module      : alp_dq_seq_if
// Description : Control bundle between the microsequencer and the ALP DQ/MUX
//               sequencer: request/abort/stall inputs, slice control fields
//               and status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alp_dq_seq_if #(
    parameter int CNT_W = 6
);
    // Microsequencer -> sequencer
    logic             start_h;
    logic             op_h;
    logic             stall_h;
    logic             abort_h;
    logic             alu_sign_h;
    // Sequencer -> ALP slices / microsequencer
    logic             dmove_h;
    logic             dreg_inh_l;
    logic [1:0]       dq_h;
    logic [3:0]       mux_h;
    logic             alu_sub_h;
    logic             busy_h;
    logic             done_h;
    logic [CNT_W-1:0] step_h;

    // Microsequencer side
    modport master (
        output start_h, op_h, stall_h, abort_h, alu_sign_h,
        input  dmove_h, dreg_inh_l, dq_h, mux_h, alu_sub_h, busy_h, done_h, step_h
    );

    // Sequencer side
    modport slave (
        input  start_h, op_h, stall_h, abort_h, alu_sign_h,
        output dmove_h, dreg_inh_l, dq_h, mux_h, alu_sub_h, busy_h, done_h, step_h
    );
endinterface

`default_nettype wire

// File: rtl/alp_dq_seq.sv
// ============================================================================
// Module      : alp_dq_seq
// Description : Multi-cycle DMOVE/DREG_INH/DQ/MUX sequencer for the ALP slices.
//               Loads Q, then runs WIDTH multiply (Q right) or non-restoring
//               divide (Q left) steps, then pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alp_dq_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  wire logic   clk,
    input  wire logic   reset,
    alp_dq_seq_if.slave bus
);

    // Sequencer states
    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_LOAD = 2'd1;
    localparam logic [1:0] C_ST_STEP = 2'd2;
    localparam logic [1:0] C_ST_DONE = 2'd3;

    // Control codes {dmove_h, dreg_inh_l, dq_h[1:0], mux_h[3:0]}
    localparam logic [7:0] C_CODE_HOLD  = 8'b0_0_00_0100;
    localparam logic [7:0] C_CODE_LOAD  = 8'b1_1_01_0001;
    localparam logic [7:0] C_CODE_MSTEP = 8'b0_1_11_0001;
    localparam logic [7:0] C_CODE_DSTEP = 8'b0_1_10_0001;

    localparam logic [CNT_W-1:0] C_STEP_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] C_STEP_ONE  = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic             op_q, op_d;
    logic             sign_q, sign_d;

    logic [7:0]       ctrl_q, ctrl_d;
    logic             alu_sub_q, alu_sub_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             w_hold;

    // A stalled LOAD/STEP cycle emits HOLD next; abort overrides the stall
    assign w_hold = ((state_q == C_ST_LOAD) || (state_q == C_ST_STEP)) &&
                    bus.stall_h && !bus.abort_h;

    // State register: FSM state, step counter, latched op and sign history
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= C_ST_IDLE;
            step_q  <= '0;
            op_q    <= 1'b0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            op_q    <= op_d;
            sign_q  <= sign_d;
        end
    end

    // Next-state logic: abort beats stall, stall beats advance/completion
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        op_d    = op_q;
        sign_d  = sign_q;
        case (state_q)
            C_ST_IDLE: begin
                if (bus.start_h) begin
                    state_d = C_ST_LOAD;
                    op_d    = bus.op_h;
                    step_d  = '0;
                end
            end
            C_ST_LOAD: begin
                if (bus.abort_h) begin
                    state_d = C_ST_IDLE;
                    step_d  = '0;
                end else if (!bus.stall_h) begin
                    state_d = C_ST_STEP;
                    step_d  = '0;
                end
            end
            C_ST_STEP: begin
                if (bus.abort_h) begin
                    state_d = C_ST_IDLE;
                    step_d  = '0;
                end else if (!bus.stall_h) begin
                    sign_d = bus.alu_sign_h;
                    if (step_q == C_STEP_LAST) begin
                        state_d = C_ST_DONE;
                    end else begin
                        step_d = step_q + C_STEP_ONE;
                    end
                end
            end
            default: begin
                state_d = C_ST_IDLE;
                if (bus.abort_h) begin
                    step_d = '0;
                end
            end
        endcase
    end

    // Output decode from the upcoming state so codes are registered
    always_comb begin
        ctrl_d    = C_CODE_HOLD;
        alu_sub_d = 1'b0;
        busy_d    = (state_d != C_ST_IDLE);
        done_d    = (state_d == C_ST_DONE);
        if (!w_hold) begin
            case (state_d)
                C_ST_LOAD: ctrl_d = C_CODE_LOAD;
                C_ST_STEP: begin
                    ctrl_d    = op_d ? C_CODE_DSTEP : C_CODE_MSTEP;
                    // First divide step subtracts; later ones follow the previous sign
                    alu_sub_d = op_d && ((step_d == '0) || !sign_d);
                end
                default:   ctrl_d = C_CODE_HOLD;
            endcase
        end
    end

    // Output register
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q    <= C_CODE_HOLD;
            alu_sub_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            alu_sub_q <= alu_sub_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.dmove_h    = ctrl_q[7];
    assign bus.dreg_inh_l = ctrl_q[6];
    assign bus.dq_h       = ctrl_q[5:4];
    assign bus.mux_h      = ctrl_q[3:0];
    assign bus.alu_sub_h  = alu_sub_q;
    assign bus.busy_h     = busy_q;
    assign bus.done_h     = done_q;
    assign bus.step_h     = step_q;

endmodule

`default_nettype wire

// File: tb/tb_alp_dq_seq.sv
// ============================================================================
// Module      : tb_alp_dq_seq
// Description : Directed self-checking bench for alp_dq_seq (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alp_dq_seq;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    localparam logic [7:0] C_HOLD  = 8'h04;  // {0,0,00,0100}
    localparam logic [7:0] C_LOAD  = 8'hD1;  // {1,1,01,0001}
    localparam logic [7:0] C_MSTEP = 8'h71;  // {0,1,11,0001}
    localparam logic [7:0] C_DSTEP = 8'h61;  // {0,1,10,0001}

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    alp_dq_seq_if #(.CNT_W(CNT_W)) bus_if ();

    alp_dq_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock; outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] code();
        return {bus_if.dmove_h, bus_if.dreg_inh_l, bus_if.dq_h, bus_if.mux_h};
    endfunction

    task automatic chk_all(input string tag, input logic [7:0] c, input logic busy,
                           input logic done, input int step, input logic sub);
        chk({tag, "_code"}, 32'(code()), 32'(c));
        chk({tag, "_busy"}, 32'(bus_if.busy_h), 32'(busy));
        chk({tag, "_done"}, 32'(bus_if.done_h), 32'(done));
        chk({tag, "_step"}, 32'(bus_if.step_h), 32'(step));
        chk({tag, "_sub"},  32'(bus_if.alu_sub_h), 32'(sub));
    endtask

    // Sign stimulus pattern 1,0,0,1 repeating
    function automatic logic sgn(input int i);
        return ((i % 4) == 0) || ((i % 4) == 3);
    endfunction

    // Full unstalled operation, entered from an IDLE cycle; ends on the IDLE
    // cycle after DONE. keep_start leaves start_h high throughout.
    task automatic run_op(input string tag, input logic op, input bit keep_start);
        bus_if.start_h = 1'b1;
        bus_if.op_h    = op;
        tick();
        chk_all({tag, "_load"}, C_LOAD, 1'b1, 1'b0, 0, 1'b0);
        if (!keep_start) bus_if.start_h = 1'b0;
        bus_if.op_h = ~op;
        for (int i = 0; i < WIDTH; i++) begin
            tick();
            chk_all($sformatf("%s_s%0d", tag, i), op ? C_DSTEP : C_MSTEP, 1'b1, 1'b0, i,
                    op && ((i == 0) || !sgn(i - 1)));
            bus_if.alu_sign_h = sgn(i);
        end
        tick();
        bus_if.alu_sign_h = 1'b0;
        chk_all({tag, "_done"}, C_HOLD, 1'b1, 1'b1, WIDTH - 1, 1'b0);
        tick();
        chk_all({tag, "_idle"}, C_HOLD, 1'b0, 1'b0, WIDTH - 1, 1'b0);
    endtask

    initial begin
        logic seen;
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        bus_if.start_h    = 1'b0;
        bus_if.op_h       = 1'b0;
        bus_if.stall_h    = 1'b0;
        bus_if.abort_h    = 1'b0;
        bus_if.alu_sign_h = 1'b0;

        // Reset state
        tick();
        tick();
        chk_all("rst", C_HOLD, 1'b0, 1'b0, 0, 1'b0);
        reset = 1'b0;

        // Plain multiply: LOAD at 1, steps at 2..33, done at 34, idle at 35
        run_op("mul", 1'b0, 1'b0);

        // Divide with sign pattern 1,0,0,1...
        run_op("div", 1'b1, 1'b0);

        // 3-cycle stall while step 5 is shown
        bus_if.start_h = 1'b1;
        bus_if.op_h    = 1'b0;
        tick();
        chk_all("stl_load", C_LOAD, 1'b1, 1'b0, 0, 1'b0);
        bus_if.start_h = 1'b0;
        for (int i = 0; i <= 5; i++) begin
            tick();
            chk_all($sformatf("stl_s%0d", i), C_MSTEP, 1'b1, 1'b0, i, 1'b0);
        end
        bus_if.stall_h = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_all($sformatf("stl_hold%0d", k), C_HOLD, 1'b1, 1'b0, 5, 1'b0);
            if (k == 2) bus_if.stall_h = 1'b0;
        end
        for (int i = 6; i < WIDTH; i++) begin
            tick();
            chk_all($sformatf("stl_s%0d", i), C_MSTEP, 1'b1, 1'b0, i, 1'b0);
        end
        tick();
        chk_all("stl_done", C_HOLD, 1'b1, 1'b1, WIDTH - 1, 1'b0);
        tick();
        chk_all("stl_idle", C_HOLD, 1'b0, 1'b0, WIDTH - 1, 1'b0);

        // Abort together with stall at step 10
        bus_if.start_h = 1'b1;
        tick();
        chk_all("abt_load", C_LOAD, 1'b1, 1'b0, 0, 1'b0);
        bus_if.start_h = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            tick();
            chk_all($sformatf("abt_s%0d", i), C_MSTEP, 1'b1, 1'b0, i, 1'b0);
        end
        bus_if.stall_h = 1'b1;
        bus_if.abort_h = 1'b1;
        tick();
        bus_if.stall_h = 1'b0;
        bus_if.abort_h = 1'b0;
        chk_all("abt_idle", C_HOLD, 1'b0, 1'b0, 0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            seen = seen | bus_if.done_h | bus_if.busy_h;
        end
        chk("abt_no_done", 32'(seen), 32'd0);

        // Reset at divide step 7, then a clean multiply
        bus_if.start_h = 1'b1;
        bus_if.op_h    = 1'b1;
        tick();
        chk_all("rdv_load", C_LOAD, 1'b1, 1'b0, 0, 1'b0);
        bus_if.start_h = 1'b0;
        for (int i = 0; i <= 7; i++) begin
            tick();
            chk_all($sformatf("rdv_s%0d", i), C_DSTEP, 1'b1, 1'b0, i,
                    (i == 0) || !sgn(i - 1));
            bus_if.alu_sign_h = sgn(i);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus_if.alu_sign_h = 1'b0;
        chk_all("rdv_rst", C_HOLD, 1'b0, 1'b0, 0, 1'b0);
        run_op("rmul", 1'b0, 1'b0);

        // start_h held high: one IDLE cycle between DONE and next LOAD
        run_op("b2b0", 1'b0, 1'b1);
        run_op("b2b1", 1'b0, 1'b1);
        bus_if.start_h = 1'b0;
        tick();
        chk_all("b2b_end", C_HOLD, 1'b0, 1'b0, WIDTH - 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
